trs_video_bus_if: RTL and testbench

TRS_VIDEO_BUS_IF -- requirements
Module: trs_video_bus_if

---
 rtl/trs_video_pkg.sv | 35 +++
 rtl/trs_strobe_filter.sv | 171 +++++++++++++++++
 rtl/trs_video_bus_if.sv | 73 +++++++
 tb/tb_trs_video_bus_if.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/trs_video_pkg.sv
// Shared definitions for the TRS-80 video bus interface: FSM encoding, I/O port
// addresses and the data bit positions of the video mode registers.
package trs_video_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StQual,
        StActive,
        StRecover
    } strobe_state_e;

    typedef enum logic {
        StbMem,
        StbIo
    } strobe_kind_e;

    localparam logic [7:0] PortMod   = 8'hEC;
    localparam logic [7:0] PortOpreg = 8'h84;

    localparam int unsigned ModselBit   = 2;
    localparam int unsigned EnaltsetBit = 3;
    localparam int unsigned InvvideBit  = 3;
    localparam int unsigned PageBit     = 7;

    // Mode register write request, valid on the edge that qualifies an OUT.
    typedef struct packed {
        logic mod_we;
        logic opreg_we;
        logic modsel;
        logic enaltset;
        logic invvide;
        logic page;
    } io_wr_t;

endpackage

// File: rtl/trs_strobe_filter.sv
// Synchronizes the raw Z80 bus and qualifies the WR/OUT strobe pair through a
// glitch filter FSM, producing one pulse and one address/data capture per strobe.
module trs_strobe_filter
    import trs_video_pkg::*;
#(
    parameter int unsigned FILTER = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_n_i,
    input  logic        out_n_i,
    input  logic [15:0] a_i,
    input  logic [7:0]  d_i,
    output logic [15:0] a_lat_o,
    output logic [7:0]  d_lat_o,
    output logic        wr_pulse_o,
    output logic        out_pulse_o,
    output io_wr_t      io_wr_o
);

    localparam logic [2:0] FilterCnt = 3'(FILTER);

    logic [1:0]    wr_s_q, out_s_q;
    logic [15:0]   a_s1_q, a_s2_q;
    logic [7:0]    d_s1_q, d_s2_q;
    strobe_state_e state_q;
    strobe_kind_e  kind_q, fire_kind;
    logic [2:0]    count_q, count_inc;
    logic [1:0]    settle_q;
    logic          armed_q;
    logic [15:0]   a_lat_q;
    logic [7:0]    d_lat_q;
    logic          wr_pulse_q, out_pulse_q;
    logic          wr_low, out_low, only_wr, only_out, both_high, same_low, kind_high;
    logic          fire, fire_io;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_s_q  <= 2'b11;
            out_s_q <= 2'b11;
            a_s1_q  <= '0;
            a_s2_q  <= '0;
            d_s1_q  <= '0;
            d_s2_q  <= '0;
        end else begin
            wr_s_q  <= {wr_s_q[0], wr_n_i};
            out_s_q <= {out_s_q[0], out_n_i};
            a_s1_q  <= a_i;
            a_s2_q  <= a_s1_q;
            d_s1_q  <= d_i;
            d_s2_q  <= d_s1_q;
        end
    end

    assign wr_low    = !wr_s_q[1];
    assign out_low   = !out_s_q[1];
    assign only_wr   = wr_low && !out_low;
    assign only_out  = out_low && !wr_low;
    assign both_high = !wr_low && !out_low;
    assign same_low  = (kind_q == StbMem) ? only_wr : only_out;
    assign kind_high = (kind_q == StbMem) ? !wr_low : !out_low;
    assign count_inc = count_q + 3'd1;

    always_comb begin
        fire      = 1'b0;
        fire_kind = kind_q;
        case (state_q)
            StIdle: begin
                if (armed_q && (only_wr || only_out) && (FilterCnt == 3'd1)) begin
                    fire      = 1'b1;
                    fire_kind = only_wr ? StbMem : StbIo;
                end
            end
            StQual: begin
                if (same_low && (count_inc == FilterCnt)) begin
                    fire = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign fire_io          = fire && (fire_kind == StbIo);
    assign io_wr_o.mod_we   = fire_io && (a_s2_q[7:0] == PortMod);
    assign io_wr_o.opreg_we = fire_io && (a_s2_q[7:0] == PortOpreg);
    assign io_wr_o.modsel   = d_s2_q[ModselBit];
    assign io_wr_o.enaltset = d_s2_q[EnaltsetBit];
    assign io_wr_o.invvide  = d_s2_q[InvvideBit];
    assign io_wr_o.page     = d_s2_q[PageBit];

    // Out of reset the FSM is unarmed: it waits for the synchronizer to flush,
    // then needs FILTER clean high samples so a strobe held across reset is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            kind_q      <= StbMem;
            count_q     <= '0;
            settle_q    <= '0;
            armed_q     <= 1'b0;
            a_lat_q     <= '0;
            d_lat_q     <= '0;
            wr_pulse_q  <= 1'b0;
            out_pulse_q <= 1'b0;
        end else begin
            wr_pulse_q  <= fire && (fire_kind == StbMem);
            out_pulse_q <= fire_io;
            if (fire) begin
                a_lat_q <= a_s2_q;
                d_lat_q <= d_s2_q;
            end
            unique case (state_q)
                StIdle: begin
                    if (!armed_q) begin
                        if (!settle_q[1]) begin
                            settle_q <= {settle_q[0], 1'b1};
                        end else if (!both_high) begin
                            count_q <= '0;
                        end else if (count_inc == FilterCnt) begin
                            armed_q <= 1'b1;
                            count_q <= '0;
                        end else begin
                            count_q <= count_inc;
                        end
                    end else if (only_wr || only_out) begin
                        kind_q <= only_wr ? StbMem : StbIo;
                        if (fire) begin
                            state_q <= StActive;
                            count_q <= '0;
                        end else begin
                            state_q <= StQual;
                            count_q <= 3'd1;
                        end
                    end
                end
                StQual: begin
                    if (!same_low) begin
                        state_q <= StIdle;
                        count_q <= '0;
                    end else if (fire) begin
                        state_q <= StActive;
                        count_q <= '0;
                    end else begin
                        count_q <= count_inc;
                    end
                end
                StActive: begin
                    if (kind_high) begin
                        state_q <= StRecover;
                        count_q <= '0;
                    end
                end
                StRecover: begin
                    if (!both_high) begin
                        count_q <= '0;
                    end else if (count_inc == FilterCnt) begin
                        state_q <= StIdle;
                        count_q <= '0;
                    end else begin
                        count_q <= count_inc;
                    end
                end
            endcase
        end
    end

    assign a_lat_o     = a_lat_q;
    assign d_lat_o     = d_lat_q;
    assign wr_pulse_o  = wr_pulse_q;
    assign out_pulse_o = out_pulse_q;

endmodule

// File: rtl/trs_video_bus_if.sv
// TRS-80 video bus snooper: qualified Z80 write strobes, display window decode
// and the video mode registers written through I/O ports.
module trs_video_bus_if
    import trs_video_pkg::*;
#(
    parameter int unsigned FILTER   = 3,
    parameter logic [15:0] DSP_BASE = 16'h3C00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] TRS_A,
    input  logic [7:0]  TRS_D,
    input  logic        TRS_WR_N,
    input  logic        TRS_OUT_N,
    output logic [15:0] A_lat,
    output logic [7:0]  D_lat,
    output logic        WR_falling_edge,
    output logic        OUT_falling_edge,
    output logic        z80_dsp_sel,
    output logic        mod_modsel,
    output logic        mod_enaltset,
    output logic        opreg_invvide,
    output logic        opreg_page
);

    io_wr_t      io_wr;
    logic [15:0] dsp_off;
    logic        modsel_q, enaltset_q, invvide_q, page_q;

    trs_strobe_filter #(
        .FILTER (FILTER)
    ) u_filter (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_n_i      (TRS_WR_N),
        .out_n_i     (TRS_OUT_N),
        .a_i         (TRS_A),
        .d_i         (TRS_D),
        .a_lat_o     (A_lat),
        .d_lat_o     (D_lat),
        .wr_pulse_o  (WR_falling_edge),
        .out_pulse_o (OUT_falling_edge),
        .io_wr_o     (io_wr)
    );

    // 16-bit subtraction: addresses below the base wrap high and fall outside.
    assign dsp_off     = A_lat - DSP_BASE;
    assign z80_dsp_sel = (dsp_off < 16'h0400);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            modsel_q   <= 1'b0;
            enaltset_q <= 1'b0;
            invvide_q  <= 1'b0;
            page_q     <= 1'b0;
        end else begin
            if (io_wr.mod_we) begin
                modsel_q   <= io_wr.modsel;
                enaltset_q <= io_wr.enaltset;
            end
            if (io_wr.opreg_we) begin
                invvide_q <= io_wr.invvide;
                page_q    <= io_wr.page;
            end
        end
    end

    assign mod_modsel    = modsel_q;
    assign mod_enaltset  = enaltset_q;
    assign opreg_invvide = invvide_q;
    assign opreg_page    = page_q;

endmodule

// File: tb/tb_trs_video_bus_if.sv
// Directed bench for trs_video_bus_if with default FILTER=3 and DSP_BASE=3C00.
module tb_trs_video_bus_if;

    logic        clk;
    logic        rst_n;
    logic [15:0] TRS_A;
    logic [7:0]  TRS_D;
    logic        TRS_WR_N;
    logic        TRS_OUT_N;
    logic [15:0] A_lat;
    logic [7:0]  D_lat;
    logic        WR_falling_edge;
    logic        OUT_falling_edge;
    logic        z80_dsp_sel;
    logic        mod_modsel;
    logic        mod_enaltset;
    logic        opreg_invvide;
    logic        opreg_page;

    int n_checks = 0;
    int n_errors = 0;

    trs_video_bus_if dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .TRS_A            (TRS_A),
        .TRS_D            (TRS_D),
        .TRS_WR_N         (TRS_WR_N),
        .TRS_OUT_N        (TRS_OUT_N),
        .A_lat            (A_lat),
        .D_lat            (D_lat),
        .WR_falling_edge  (WR_falling_edge),
        .OUT_falling_edge (OUT_falling_edge),
        .z80_dsp_sel      (z80_dsp_sel),
        .mod_modsel       (mod_modsel),
        .mod_enaltset     (mod_enaltset),
        .opreg_invvide    (opreg_invvide),
        .opreg_page       (opreg_page)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // kind: 0 = memory write, 1 = I/O write, 2 = both strobes together.
    // lat is the number of clocks from the first edge sampling low to the pulse.
    task automatic do_strobe(input int kind, input logic [15:0] addr, input logic [7:0] data,
                             input int low_cycles, output int wr_cnt, output int out_cnt,
                             output int lat);
        wr_cnt  = 0;
        out_cnt = 0;
        lat     = -1;
        @(negedge clk);
        TRS_A = addr;
        TRS_D = data;
        if (kind != 1) TRS_WR_N = 1'b0;
        if (kind != 0) TRS_OUT_N = 1'b0;
        for (int i = 1; i <= low_cycles + 10; i++) begin
            @(posedge clk);
            #1;
            if (WR_falling_edge || OUT_falling_edge) begin
                if (lat < 0) lat = i - 1;
            end
            if (WR_falling_edge) wr_cnt++;
            if (OUT_falling_edge) out_cnt++;
            if (i == low_cycles) begin
                @(negedge clk);
                TRS_WR_N  = 1'b1;
                TRS_OUT_N = 1'b1;
            end
        end
    endtask

    // Expected display-window select for each boundary address.
    logic [15:0] bnd_addr [5] = '{16'h3BFF, 16'h4000, 16'hFFFF, 16'h3C00, 16'h3FFF};
    logic        bnd_sel  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        int wr_cnt, out_cnt, lat;
        rst_n     = 1'b0;
        TRS_A     = 16'h0000;
        TRS_D     = 8'h00;
        TRS_WR_N  = 1'b1;
        TRS_OUT_N = 1'b1;
        #12;
        check_eq("rst_a_lat", 32'(A_lat), 32'h0);
        check_eq("rst_d_lat", 32'(D_lat), 32'h0);
        check_eq("rst_pulses", 32'({WR_falling_edge, OUT_falling_edge}), 32'h0);
        check_eq("rst_dsp_sel", 32'(z80_dsp_sel), 32'h0);
        check_eq("rst_mode", 32'({mod_modsel, mod_enaltset, opreg_invvide, opreg_page}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);

        do_strobe(0, 16'h3C05, 8'h41, 10, wr_cnt, out_cnt, lat);
        check_eq("mem_wr_pulses", 32'(wr_cnt), 32'd1);
        check_eq("mem_out_pulses", 32'(out_cnt), 32'd0);
        check_eq("mem_latency", 32'(lat), 32'd4);
        check_eq("mem_a_lat", 32'(A_lat), 32'h3C05);
        check_eq("mem_d_lat", 32'(D_lat), 32'h41);
        check_eq("mem_dsp_sel", 32'(z80_dsp_sel), 32'h1);

        do_strobe(0, 16'h1234, 8'h99, 2, wr_cnt, out_cnt, lat);
        check_eq("glitch_pulses", 32'(wr_cnt + out_cnt), 32'd0);
        check_eq("glitch_a_lat", 32'(A_lat), 32'h3C05);
        check_eq("glitch_d_lat", 32'(D_lat), 32'h41);

        do_strobe(1, 16'h00EC, 8'h04, 8, wr_cnt, out_cnt, lat);
        check_eq("port_out_pulses", 32'(out_cnt), 32'd1);
        check_eq("port_wr_pulses", 32'(wr_cnt), 32'd0);
        check_eq("port_latency", 32'(lat), 32'd4);
        check_eq("port_modsel", 32'(mod_modsel), 32'h1);
        check_eq("port_enaltset", 32'(mod_enaltset), 32'h0);
        check_eq("port_a_lat", 32'(A_lat), 32'h00EC);

        do_strobe(0, 16'h3CEC, 8'h08, 6, wr_cnt, out_cnt, lat);
        check_eq("memec_mode", 32'({mod_modsel, mod_enaltset}), 32'b10);
        do_strobe(1, 16'h00ED, 8'hFF, 6, wr_cnt, out_cnt, lat);
        check_eq("other_port_mode", 32'({mod_modsel, mod_enaltset, opreg_invvide, opreg_page}),
                 32'b1000);
        check_eq("other_port_d_lat", 32'(D_lat), 32'hFF);
        do_strobe(1, 16'h00EC, 8'h08, 6, wr_cnt, out_cnt, lat);
        check_eq("port_ec_08_mode", 32'({mod_modsel, mod_enaltset}), 32'b01);

        for (int i = 0; i < 5; i++) begin
            do_strobe(0, bnd_addr[i], 8'h20, 5, wr_cnt, out_cnt, lat);
            check_eq($sformatf("bnd_%04h_pulse", bnd_addr[i]), 32'(wr_cnt), 32'd1);
            check_eq($sformatf("bnd_%04h_sel", bnd_addr[i]), 32'(z80_dsp_sel), 32'(bnd_sel[i]));
        end

        do_strobe(2, 16'h3C20, 8'h77, 10, wr_cnt, out_cnt, lat);
        check_eq("contention_pulses", 32'(wr_cnt + out_cnt), 32'd0);
        check_eq("contention_a_lat", 32'(A_lat), 32'h3FFF);
        do_strobe(0, 16'h3C10, 8'h55, 6, wr_cnt, out_cnt, lat);
        check_eq("after_cont_pulses", 32'(wr_cnt), 32'd1);
        check_eq("after_cont_latency", 32'(lat), 32'd4);
        check_eq("after_cont_a_lat", 32'(A_lat), 32'h3C10);

        // OUT 88 to port 84, then reset while the strobe is still held low.
        @(negedge clk);
        TRS_A     = 16'h0084;
        TRS_D     = 8'h88;
        TRS_OUT_N = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check_eq("pre_rst_opreg", 32'({opreg_invvide, opreg_page}), 32'b11);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_opreg", 32'({opreg_invvide, opreg_page}), 32'b00);
        check_eq("mid_rst_mod", 32'({mod_modsel, mod_enaltset}), 32'b00);
        check_eq("mid_rst_lat", 32'({A_lat, D_lat}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        out_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (OUT_falling_edge || WR_falling_edge) out_cnt++;
        end
        check_eq("held_low_pulses", 32'(out_cnt), 32'd0);
        @(negedge clk);
        TRS_OUT_N = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        TRS_D     = 8'h80;
        TRS_OUT_N = 1'b0;
        out_cnt = 0;
        lat     = -1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (OUT_falling_edge) begin
                out_cnt++;
                if (lat < 0) lat = i - 1;
            end
        end
        @(negedge clk);
        TRS_OUT_N = 1'b1;
        repeat (10) @(posedge clk);
        check_eq("rearm_pulses", 32'(out_cnt), 32'd1);
        check_eq("rearm_latency", 32'(lat), 32'd4);
        check_eq("rearm_opreg", 32'({opreg_invvide, opreg_page}), 32'b01);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
